// File: rtl/control_unit_if.sv
// Bundle of the control unit's instruction input and datapath control strobes.
// The master side is the control unit and the slave side is the datapath.
interface control_unit_if;
    logic [15:0] ir;
    logic        pc_clr;
    logic        pc_up;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [2:0]  alu_s0;
    logic [3:0]  out_state;

    modport master (
        input  ir,
        output pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s0, out_state
    );

    modport slave (
        output ir,
        input  pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
               rf_ra_addr, rf_rb_addr, alu_s0, out_state
    );
endinterface

// File: rtl/control_unit.sv
// Moore-FSM control unit for a small load/store CPU (fetch, decode, execute).
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes trap to Halt instead of executing as Noop.
module control_unit (
    input  logic            i_clk,
    input  logic            i_rst_n,
    control_unit_if.master  io_cu
);
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOADA  = 4'd4,
        ST_LOADB  = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    state_e      r_state;
    state_e      w_next_state;
    logic [3:0]  w_opcode;
    logic        w_pc_clr;
    logic        w_pc_up;
    logic        w_ir_ld;
    logic [7:0]  w_d_addr;
    logic        w_d_wr;
    logic        w_rf_s;
    logic [3:0]  w_rf_w_addr;
    logic        w_rf_w_en;
    logic [3:0]  w_rf_ra_addr;
    logic [3:0]  w_rf_rb_addr;
    logic [2:0]  w_alu_s0;

    assign w_opcode = io_cu.ir[15:12];

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and Moore outputs from the current state and IR fields.
    always_comb begin
        w_next_state = r_state;
        w_pc_clr     = 1'b0;
        w_pc_up      = 1'b0;
        w_ir_ld      = 1'b0;
        w_d_addr     = 8'h00;
        w_d_wr       = 1'b0;
        w_rf_s       = 1'b0;
        w_rf_w_addr  = 4'h0;
        w_rf_w_en    = 1'b0;
        w_rf_ra_addr = 4'h0;
        w_rf_rb_addr = 4'h0;
        w_alu_s0     = 3'b000;
        case (r_state)
            ST_INIT: begin
                w_pc_clr     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_ir_ld      = 1'b1;
                w_pc_up      = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                // Memory address goes out a cycle early so the synchronous read lines up.
                if ((w_opcode == 4'b0001) || (w_opcode == 4'b0010)) begin
                    w_d_addr = io_cu.ir[11:4];
                end else begin
                    w_d_addr = 8'h00;
                end
                case (w_opcode)
                    4'b0000: w_next_state = ST_NOOP;
                    4'b0001: w_next_state = ST_STORE;
                    4'b0010: w_next_state = ST_LOADA;
                    4'b0011: w_next_state = ST_ADD;
                    4'b0100: w_next_state = ST_SUB;
                    4'b0101: w_next_state = ST_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                    default: w_next_state = ST_HALT;
`else
                    default: w_next_state = ST_NOOP;
`endif
                endcase
            end
            ST_NOOP: begin
                w_next_state = ST_FETCH;
            end
            ST_LOADA: begin
                w_d_addr     = io_cu.ir[11:4];
                w_rf_s       = 1'b1;
                w_rf_w_addr  = io_cu.ir[3:0];
                w_next_state = ST_LOADB;
            end
            ST_LOADB: begin
                w_d_addr     = io_cu.ir[11:4];
                w_rf_s       = 1'b1;
                w_rf_w_addr  = io_cu.ir[3:0];
                w_rf_w_en    = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_STORE: begin
                w_d_addr     = io_cu.ir[11:4];
                w_rf_ra_addr = io_cu.ir[3:0];
                w_d_wr       = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_ADD: begin
                w_rf_ra_addr = io_cu.ir[11:8];
                w_rf_rb_addr = io_cu.ir[7:4];
                w_rf_w_addr  = io_cu.ir[3:0];
                w_rf_w_en    = 1'b1;
                w_alu_s0     = 3'b001;
                w_next_state = ST_FETCH;
            end
            ST_SUB: begin
                w_rf_ra_addr = io_cu.ir[11:8];
                w_rf_rb_addr = io_cu.ir[7:4];
                w_rf_w_addr  = io_cu.ir[3:0];
                w_rf_w_en    = 1'b1;
                w_alu_s0     = 3'b010;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    assign io_cu.pc_clr     = w_pc_clr;
    assign io_cu.pc_up      = w_pc_up;
    assign io_cu.ir_ld      = w_ir_ld;
    assign io_cu.d_addr     = w_d_addr;
    assign io_cu.d_wr       = w_d_wr;
    assign io_cu.rf_s       = w_rf_s;
    assign io_cu.rf_w_addr  = w_rf_w_addr;
    assign io_cu.rf_w_en    = w_rf_w_en;
    assign io_cu.rf_ra_addr = w_rf_ra_addr;
    assign io_cu.rf_rb_addr = w_rf_rb_addr;
    assign io_cu.alu_s0     = w_alu_s0;
    assign io_cu.out_state  = r_state;
endmodule
